pop_sequence_scheduler: RTL and testbench

Sequencer for the POP (pulsed optically pumped) timing outputs. It latches one sequence configuration and plays it as a fixed phase order: pump, dark, MW, dark, probe. The sample window is nested inside probe, and the whole cycle repeats a programmed number of times. It replaces free-running generation of pump/probe/MW/sample with a start/abort-controlled, reconfigurable schedule.

---
 rtl/pop_timing_pkg.sv | 29 ++
 rtl/pop_phase_counter.sv | 37 +++
 rtl/pop_sequence_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pop_sequence_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pop_timing_pkg.sv
// rtl/pop_timing_pkg.sv - shared state encoding and phase-order helper for the POP scheduler
package pop_timing_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_REPS_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUMP  = 3'd1,
        DARK1 = 3'd2,
        MW    = 3'd3,
        DARK2 = 3'd4,
        PROBE = 3'd5,
        DONE  = 3'd6
    } pop_state_t;

    // nz[i-1] flags a nonzero length for phase encoding i; DONE means no later phase remains.
    function automatic pop_state_t next_phase(input pop_state_t cur, input logic [4:0] nz);
        pop_state_t nxt;
        nxt = DONE;
        for (int i = 5; i >= 1; i--) begin
            if (i > int'(cur) && nz[i-1]) begin
                nxt = pop_state_t'(i[2:0]);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pop_phase_counter.sv
// rtl/pop_phase_counter.sv - loadable down-counter with last-cycle flag and elapsed index
module pop_phase_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_last,
    output logic [WIDTH-1:0] o_idx
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_remain;
    logic [WIDTH-1:0] r_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remain <= '0;
            r_idx    <= '0;
        end else if (i_load) begin
            r_remain <= i_load_val;
            r_idx    <= '0;
        end else if (i_en) begin
            if (r_remain != '0) begin
                r_remain <= r_remain - ONE;
            end
            r_idx <= r_idx + ONE;
        end
    end

    assign o_last = (r_remain == ONE);
    assign o_idx  = r_idx;

endmodule

// File: rtl/pop_sequence_scheduler.sv
// rtl/pop_sequence_scheduler.sv - plays pump/dark/MW/dark/probe with nested sample window, repeated
module pop_sequence_scheduler
    import pop_timing_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int REPS_WIDTH = DEFAULT_REPS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_pump_len,
    input  logic [WIDTH-1:0]      cfg_dark1_len,
    input  logic [WIDTH-1:0]      cfg_mw_len,
    input  logic [WIDTH-1:0]      cfg_dark2_len,
    input  logic [WIDTH-1:0]      cfg_probe_len,
    input  logic [WIDTH-1:0]      cfg_sample_dly,
    input  logic [WIDTH-1:0]      cfg_sample_len,
    input  logic [REPS_WIDTH-1:0] cfg_reps,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_loaded,
    output logic                  pump,
    output logic                  mw,
    output logic                  probe,
    output logic                  sample,
    output logic [REPS_WIDTH-1:0] rep_count
);

    localparam logic [REPS_WIDTH-1:0] REP_ONE  = {{(REPS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REPS_WIDTH:0]   REP_ONEX = {{REPS_WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]        K_ONE    = {{WIDTH{1'b0}}, 1'b1};

    pop_state_t            r_state;
    logic [WIDTH-1:0]      r_pump_len, r_dark1_len, r_mw_len, r_dark2_len, r_probe_len;
    logic [WIDTH-1:0]      r_sample_dly, r_sample_len;
    logic [REPS_WIDTH-1:0] r_reps;
    logic                  r_cfg_loaded;
    logic [REPS_WIDTH-1:0] r_rep_count;
    logic                  r_pump, r_mw, r_probe, r_sample, r_busy, r_done;

    logic [4:0]            w_nz;
    pop_state_t            w_first, w_after, w_next;
    logic                  w_in_phase, w_next_in_phase, w_last, w_more;
    logic                  w_start_ok, w_rep_inc, w_load, w_sample_next;
    logic [WIDTH-1:0]      w_idx, w_load_val;
    logic [WIDTH:0]        w_k_next;

    assign w_nz = {r_probe_len != '0, r_dark2_len != '0, r_mw_len != '0,
                   r_dark1_len != '0, r_pump_len != '0};
    assign w_first    = next_phase(IDLE, w_nz);
    assign w_after    = next_phase(r_state, w_nz);
    assign w_in_phase = (r_state != IDLE) && (r_state != DONE);
    assign w_more     = (r_reps == '0) || (({1'b0, r_rep_count} + REP_ONEX) < {1'b0, r_reps});

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_rep_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && r_cfg_loaded && !abort) begin
                    w_next     = w_first;
                    w_start_ok = 1'b1;
                end
            end
            PUMP, DARK1, MW, DARK2, PROBE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    if (w_after != DONE) begin
                        w_next = w_after;
                    end else if (w_more) begin
                        w_next    = w_first;
                        w_rep_inc = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_next_in_phase = (w_next != IDLE) && (w_next != DONE);
    // A reload is needed even when the next phase equals the current one (single-phase loops).
    assign w_load = w_next_in_phase && (w_start_ok || (w_in_phase && w_last));

    always_comb begin
        w_load_val = '0;
        case (w_next)
            PUMP:    w_load_val = r_pump_len;
            DARK1:   w_load_val = r_dark1_len;
            MW:      w_load_val = r_mw_len;
            DARK2:   w_load_val = r_dark2_len;
            PROBE:   w_load_val = r_probe_len;
            default: w_load_val = '0;
        endcase
    end

    pop_phase_counter #(.WIDTH(WIDTH)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_in_phase),
        .o_last     (w_last),
        .o_idx      (w_idx)
    );

    // Sample is registered, so it is decided from the probe index of the coming cycle.
    assign w_k_next      = w_load ? '0 : ({1'b0, w_idx} + K_ONE);
    assign w_sample_next = (w_next == PROBE)
                        && ({1'b0, r_sample_dly} <= w_k_next)
                        && (w_k_next < ({1'b0, r_sample_dly} + {1'b0, r_sample_len}));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pump_len   <= '0;
            r_dark1_len  <= '0;
            r_mw_len     <= '0;
            r_dark2_len  <= '0;
            r_probe_len  <= '0;
            r_sample_dly <= '0;
            r_sample_len <= '0;
            r_reps       <= '0;
            r_cfg_loaded <= 1'b0;
            r_rep_count  <= '0;
            r_pump       <= 1'b0;
            r_mw         <= 1'b0;
            r_probe      <= 1'b0;
            r_sample     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cfg_valid) begin
                r_pump_len   <= cfg_pump_len;
                r_dark1_len  <= cfg_dark1_len;
                r_mw_len     <= cfg_mw_len;
                r_dark2_len  <= cfg_dark2_len;
                r_probe_len  <= cfg_probe_len;
                r_sample_dly <= cfg_sample_dly;
                r_sample_len <= cfg_sample_len;
                r_reps       <= cfg_reps;
                r_cfg_loaded <= 1'b1;
            end
            if (w_start_ok) begin
                r_rep_count <= '0;
            end else if (w_rep_inc) begin
                r_rep_count <= r_rep_count + REP_ONE;
            end
            r_pump   <= (w_next == PUMP);
            r_mw     <= (w_next == MW);
            r_probe  <= (w_next == PROBE);
            r_sample <= w_sample_next;
            r_busy   <= w_next_in_phase;
            r_done   <= (w_next == DONE);
        end
    end

    assign cfg_ready  = (r_state == IDLE);
    assign cfg_loaded = r_cfg_loaded;
    assign rep_count  = r_rep_count;
    assign pump       = r_pump;
    assign mw         = r_mw;
    assign probe      = r_probe;
    assign sample     = r_sample;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_pop_sequence_scheduler.sv
// tb/tb_pop_sequence_scheduler.sv - randomized and directed checks against a per-cycle trace model
module tb_pop_sequence_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_ready;
    logic [15:0] cfg_pump_len, cfg_dark1_len, cfg_mw_len, cfg_dark2_len, cfg_probe_len;
    logic [15:0] cfg_sample_dly, cfg_sample_len;
    logic [7:0]  cfg_reps;
    logic        start, abort;
    logic        busy, done, cfg_loaded, pump, mw, probe, sample;
    logic [7:0]  rep_count;

    pop_sequence_scheduler dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pump_len(cfg_pump_len), .cfg_dark1_len(cfg_dark1_len), .cfg_mw_len(cfg_mw_len),
        .cfg_dark2_len(cfg_dark2_len), .cfg_probe_len(cfg_probe_len),
        .cfg_sample_dly(cfg_sample_dly), .cfg_sample_len(cfg_sample_len), .cfg_reps(cfg_reps),
        .start(start), .abort(abort), .busy(busy), .done(done), .cfg_loaded(cfg_loaded),
        .pump(pump), .mw(mw), .probe(probe), .sample(sample), .rep_count(rep_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] outs;
        int         rep;
    } exp_t;

    exp_t exp_q[$];
    int   m_len[5];
    int   m_dly, m_slen, m_reps;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] get_outs();
        return {pump, mw, probe, sample, busy, done};
    endfunction

    task automatic set_cfg(input int p, input int d1, input int w, input int d2, input int pr,
                           input int dly, input int slen, input int reps);
        m_len[0] = p; m_len[1] = d1; m_len[2] = w; m_len[3] = d2; m_len[4] = pr;
        m_dly = dly; m_slen = slen; m_reps = reps;
    endtask

    task automatic load_cfg();
        cfg_pump_len   = 16'(m_len[0]);
        cfg_dark1_len  = 16'(m_len[1]);
        cfg_mw_len     = 16'(m_len[2]);
        cfg_dark2_len  = 16'(m_len[3]);
        cfg_probe_len  = 16'(m_len[4]);
        cfg_sample_dly = 16'(m_dly);
        cfg_sample_len = 16'(m_slen);
        cfg_reps       = 8'(m_reps);
        cfg_valid      = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_eq("cfg_loaded", 32'(cfg_loaded), 1);
    endtask

    // Expected per-cycle outputs {pump,mw,probe,sample,busy,done} and rep_count after start.
    task automatic build(input int nreps, input bit with_done);
        int   total;
        exp_t e;
        exp_q.delete();
        total = 0;
        for (int p = 0; p < 5; p++) total += m_len[p];
        if (total == 0) begin
            e.outs = 6'b000001; e.rep = 0;
            exp_q.push_back(e);
            return;
        end
        for (int r = 0; r < nreps; r++) begin
            for (int p = 0; p < 5; p++) begin
                for (int c = 0; c < m_len[p]; c++) begin
                    e.outs = {p == 0, p == 2, p == 4,
                              (p == 4) && (c >= m_dly) && (c < m_dly + m_slen), 1'b1, 1'b0};
                    e.rep  = r;
                    exp_q.push_back(e);
                end
            end
        end
        if (with_done) begin
            e.outs = 6'b000001; e.rep = nreps - 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_seq(input string name, input int abort_at, input bit noise,
                           output int done_at, output int n_done);
        done_at = -1;
        n_done  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq({name, "_outs"}, 32'(get_outs()), 32'(exp_q[i].outs));
            check_eq({name, "_rep"}, 32'(rep_count), exp_q[i].rep);
            if (done) begin
                n_done++;
                done_at = i + 1;
            end
            if (i == abort_at) begin
                abort = 1'b1; cfg_valid = 1'b0; start = 1'b0;
                tick();
                abort = 1'b0;
                check_eq({name, "_abort_outs"}, 32'(get_outs()), 0);
                check_eq({name, "_abort_ready"}, 32'(cfg_ready), 1);
                check_eq({name, "_abort_rep"}, 32'(rep_count), exp_q[i].rep);
                return;
            end
            if (noise) begin
                cfg_valid      = 1'b1;
                cfg_pump_len   = 16'($urandom_range(0, 15));
                cfg_mw_len     = 16'($urandom_range(0, 15));
                cfg_probe_len  = 16'($urandom_range(0, 15));
                cfg_sample_dly = 16'($urandom_range(0, 15));
                cfg_reps       = 8'($urandom_range(0, 3));
                start          = 1'($urandom_range(0, 1));
            end
            tick();
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        check_eq({name, "_end_outs"}, 32'(get_outs()), 0);
        check_eq({name, "_end_ready"}, 32'(cfg_ready), 1);
    endtask

    initial begin
        int done_at, n_done, abort_at;
        reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        cfg_pump_len = '0; cfg_dark1_len = '0; cfg_mw_len = '0; cfg_dark2_len = '0;
        cfg_probe_len = '0; cfg_sample_dly = '0; cfg_sample_len = '0; cfg_reps = '0;
        repeat (3) tick();
        check_eq("reset_outs", 32'(get_outs()), 0);
        check_eq("reset_loaded", 32'(cfg_loaded), 0);
        check_eq("reset_rep", 32'(rep_count), 0);
        check_eq("reset_ready", 32'(cfg_ready), 1);
        reset = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("nocfg_outs", 32'(get_outs()), 0);
            tick();
        end

        set_cfg(5, 3, 4, 2, 6, 1, 3, 1);
        load_cfg();
        build(1, 1);
        run_seq("basic", -1, 0, done_at, n_done);
        check_eq("basic_done_cycle", done_at, 21);

        set_cfg(2, 3, 0, 0, 4, 2, 10, 1);
        load_cfg();
        build(1, 1);
        run_seq("skipclip", -1, 0, done_at, n_done);

        set_cfg(2, 2, 2, 2, 2, 0, 1, 3);
        load_cfg();
        build(3, 1);
        run_seq("reps", -1, 0, done_at, n_done);
        check_eq("reps_single_done", n_done, 1);
        check_eq("reps_final_count", 32'(rep_count), 2);

        set_cfg(5, 3, 4, 2, 6, 1, 3, 0);
        load_cfg();
        build(3, 0);
        abort_at = -1;
        n_done = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].outs[4]) begin
                n_done++;
                if (n_done == 2) begin
                    abort_at = i;
                    break;
                end
            end
        end
        run_seq("abort_mw", abort_at, 0, done_at, n_done);
        check_eq("abort_mw_nodone", n_done, 0);

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("abort_start_idle_outs", 32'(get_outs()), 0);
        check_eq("abort_start_idle_ready", 32'(cfg_ready), 1);

        set_cfg(3, 1, 2, 1, 5, 1, 2, 2);
        load_cfg();
        build(2, 1);
        run_seq("noise", -1, 1, done_at, n_done);
        run_seq("after_noise", -1, 0, done_at, n_done);

        for (int t = 0; t < 10; t++) begin
            for (int p = 0; p < 5; p++) m_len[p] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
            m_dly  = $urandom_range(0, 6);
            m_slen = $urandom_range(0, 8);
            m_reps = $urandom_range(0, 3);
            load_cfg();
            if (m_reps == 0) begin
                build(3, 0);
                abort_at = (exp_q.size() > 1) ? $urandom_range(0, exp_q.size() - 1) : -1;
                run_seq("rand_cont", abort_at, 0, done_at, n_done);
            end else begin
                build(m_reps, 1);
                run_seq("rand_fin", -1, 0, done_at, n_done);
            end
        end

        set_cfg(5, 3, 4, 2, 6, 1, 3, 1);
        load_cfg();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !probe; i++) tick();
        check_eq("probe_reached", 32'(probe), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("midreset_outs", 32'(get_outs()), 0);
        check_eq("midreset_loaded", 32'(cfg_loaded), 0);
        check_eq("midreset_rep", 32'(rep_count), 0);
        check_eq("midreset_ready", 32'(cfg_ready), 1);
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("postreset_nocfg_outs", 32'(get_outs()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
